// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: mem_ops opcode package plus the signal bundle around lsu_mem_ctrl.
//   request : in_valid/in_ready/in_memop/in_addr/in_wdata/in_tag, flush
//   format  : fmt_memop/fmt_addr/fmt_wdata out, fmt_is_store/fmt_byte_enable/fmt_out in
//   dcache  : mem_d_read/mem_d_write/mem_d_address/mem_d_wdata/mem_d_byte_enable out, mem_d_resp in
//   result  : out_valid/out_tag/out_data/out_is_store (+ out_misalign under MISALIGN_TRAP_EN), out_ready
//   master modport is the controller side, slave modport is its environment.
package lsu_mem_pkg;
  typedef enum logic [2:0] {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW} mem_ops;
endpackage

interface lsu_mem_ctrl_if #(parameter int TAG_W = 5);
  import lsu_mem_pkg::*;
  logic in_valid, in_ready, flush;
  mem_ops in_memop, fmt_memop;
  logic [31:0] in_addr, in_wdata, fmt_addr, fmt_wdata, fmt_out;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic fmt_is_store;
  logic [3:0] fmt_byte_enable, mem_d_byte_enable;
  logic mem_d_read, mem_d_write, mem_d_resp;
  logic [31:0] mem_d_address, mem_d_wdata, out_data;
  logic out_valid, out_ready, out_is_store;
`ifdef MISALIGN_TRAP_EN
  logic out_misalign;
`endif
  modport master (
    input in_valid, in_memop, in_addr, in_wdata, in_tag, flush,
    input fmt_is_store, fmt_byte_enable, fmt_out, mem_d_resp, out_ready,
    output in_ready, fmt_memop, fmt_addr, fmt_wdata,
    output mem_d_read, mem_d_write, mem_d_address, mem_d_wdata, mem_d_byte_enable,
    output out_valid, out_tag, out_data, out_is_store
`ifdef MISALIGN_TRAP_EN
    , output out_misalign
`endif
  );
  modport slave (
    output in_valid, in_memop, in_addr, in_wdata, in_tag, flush,
    output fmt_is_store, fmt_byte_enable, fmt_out, mem_d_resp, out_ready,
    input in_ready, fmt_memop, fmt_addr, fmt_wdata,
    input mem_d_read, mem_d_write, mem_d_address, mem_d_wdata, mem_d_byte_enable,
    input out_valid, out_tag, out_data, out_is_store
`ifdef MISALIGN_TRAP_EN
    , input out_misalign
`endif
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: in-order load/store issue controller between reservation stage, byte formatter, dcache and CDB.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : lsu_mem_ctrl_if.master (request FIFO input, formatter, dcache, CDB result)
//   MISALIGN_TRAP_EN : when defined, misaligned lh/lhu/sh/lw/sw skip the dcache and report out_misalign
module lsu_mem_ctrl
  import lsu_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic clk,
  input  logic rst,
  lsu_mem_ctrl_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic [AW:0] count_q, count_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic kill_q, kill_d, store_q, store_d, push, pop, kill_now;
  logic [31:0] data_q, data_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  mem_ops op_q [DEPTH], op_d [DEPTH];
  logic [31:0] addr_q [DEPTH], addr_d [DEPTH], wdata_q [DEPTH], wdata_d [DEPTH];
  logic [TAG_W-1:0] etag_q [DEPTH], etag_d [DEPTH];
`ifdef MISALIGN_TRAP_EN
  logic mis_q, mis_d, head_mis;
  assign head_mis = (op_q[rd_q] inside {MEM_LH, MEM_LHU, MEM_SH} && addr_q[rd_q][0]) ||
                    (op_q[rd_q] inside {MEM_LW, MEM_SW} && addr_q[rd_q][1:0] != 2'b00);
  assign bus.out_misalign = state_q == RESP && mis_q;
`endif
  assign bus.in_ready = count_q != (AW+1)'(DEPTH) && !kill_q;
  // Head only pops on CDB handoff, so the formatter inputs stay stable through the access.
  assign bus.fmt_memop = op_q[rd_q];
  assign bus.fmt_addr = addr_q[rd_q];
  assign bus.fmt_wdata = wdata_q[rd_q];
  assign bus.mem_d_read = state_q == ACCESS && !bus.fmt_is_store;
  assign bus.mem_d_write = state_q == ACCESS && bus.fmt_is_store;
  assign bus.mem_d_address = {addr_q[rd_q][31:2], 2'b00};
  assign bus.mem_d_byte_enable = bus.fmt_byte_enable;
  assign bus.mem_d_wdata = bus.fmt_out;
  assign bus.out_valid = state_q == RESP;
  assign bus.out_tag = tag_q;
  assign bus.out_data = data_q;
  assign bus.out_is_store = store_q;
  always_comb begin
    state_d = state_q;
    kill_d = kill_q;
    data_d = data_q;
    tag_d = tag_q;
    store_d = store_q;
    op_d = op_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    etag_d = etag_q;
`ifdef MISALIGN_TRAP_EN
    mis_d = mis_q;
`endif
    push = bus.in_valid && bus.in_ready && !bus.flush;
    pop = 1'b0;
    kill_now = kill_q || bus.flush;
    if (push) begin
      op_d[wr_q] = bus.in_memop;
      addr_d[wr_q] = bus.in_addr;
      wdata_d[wr_q] = bus.in_wdata;
      etag_d[wr_q] = bus.in_tag;
    end
    case (state_q)
      IDLE: if (count_q != '0 && !bus.flush) begin
        state_d = ACCESS;
`ifdef MISALIGN_TRAP_EN
        if (head_mis) begin
          state_d = RESP;
          data_d = '0;
          tag_d = etag_q[rd_q];
          store_d = op_q[rd_q] inside {MEM_SB, MEM_SH, MEM_SW};
          mis_d = 1'b1;
        end
`endif
      end
      ACCESS: if (bus.mem_d_resp) begin
        // A squashed head is retired silently once the dcache answers.
        state_d = kill_now ? IDLE : RESP;
        pop = kill_now;
        kill_d = 1'b0;
        data_d = bus.fmt_is_store ? '0 : bus.fmt_out;
        tag_d = etag_q[rd_q];
        store_d = bus.fmt_is_store;
`ifdef MISALIGN_TRAP_EN
        mis_d = 1'b0;
`endif
      end
      RESP: begin
        pop = bus.out_ready && !bus.flush;
        state_d = (bus.out_ready || bus.flush) ? IDLE : RESP;
      end
      default: state_d = IDLE;
    endcase
    rd_d = rd_q + AW'(pop);
    wr_d = wr_q + AW'(push);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    // Flush mid-access keeps only the head, whose dcache transaction must still complete.
    if (bus.flush) begin
      kill_d = state_q == ACCESS && !bus.mem_d_resp;
      wr_d = kill_d ? rd_q + 1'b1 : rd_d;
      count_d = kill_d ? (AW+1)'(1) : '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      kill_q <= 1'b0;
      data_q <= '0;
      tag_q <= '0;
      store_q <= 1'b0;
      op_q <= '{default: MEM_LB};
      addr_q <= '{default: '0};
      wdata_q <= '{default: '0};
      etag_q <= '{default: '0};
`ifdef MISALIGN_TRAP_EN
      mis_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      kill_q <= kill_d;
      data_q <= data_d;
      tag_q <= tag_d;
      store_q <= store_d;
      op_q <= op_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      etag_q <= etag_d;
`ifdef MISALIGN_TRAP_EN
      mis_q <= mis_d;
`endif
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: bench for lsu_mem_ctrl with formatter/dcache models and a byte-level reference memory.
module tb_lsu_mem_ctrl;
  import lsu_mem_pkg::*;
  typedef struct {
    mem_ops op;
    logic [31:0] a;
    logic [31:0] wd;
    logic [4:0] tg;
  } req_t;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  lsu_mem_ctrl_if #(.TAG_W(5)) bus ();
  lsu_mem_ctrl #(.DEPTH(4), .TAG_W(5)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  int total = 0, bad = 0;
  logic [31:0] dmem [256];
  logic [7:0] rmem [1024];
  req_t expq [$];
  int lat_cfg = 1, cur_lat = 0, cyc = 0, n_resp = 0, rereq = 0, log_cyc = 0;
  bit lat_rand = 1'b0;
  logic [31:0] log_addr, log_wdata;
  logic [3:0] log_be;
  logic log_rd, log_wr;
  logic [36:0] f;

  function automatic logic [31:0] init_word(int i);
    return (i == 64) ? 32'hDEADBEEF : (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic int sz(mem_ops op);
    return (op inside {MEM_LB, MEM_LBU, MEM_SB}) ? 1 : (op inside {MEM_LH, MEM_LHU, MEM_SH}) ? 2 : 4;
  endfunction

  // Byte-lane formatter: {is_store, byte_enable, data}
  function automatic logic [36:0] fmt(mem_ops op, logic [31:0] a, logic [31:0] wd, logic [31:0] w);
    logic [4:0] s;
    logic [31:0] r;
    logic [3:0] m;
    s = {a[1:0], 3'b000};
    r = w >> s;
    m = (sz(op) == 1) ? 4'b0001 : (sz(op) == 2) ? 4'b0011 : 4'b1111;
    case (op)
      MEM_LB: r = {{24{r[7]}}, r[7:0]};
      MEM_LBU: r = {24'b0, r[7:0]};
      MEM_LH: r = {{16{r[15]}}, r[15:0]};
      MEM_LHU: r = {16'b0, r[15:0]};
      MEM_LW: r = r;
      default: r = wd << s;
    endcase
    return {op inside {MEM_SB, MEM_SH, MEM_SW}, 4'(m << a[1:0]), r};
  endfunction

  assign f = fmt(bus.fmt_memop, bus.fmt_addr, bus.fmt_wdata, dmem[bus.fmt_addr[9:2]]);
  assign bus.fmt_is_store = f[36];
  assign bus.fmt_byte_enable = f[35:32];
  assign bus.fmt_out = f[31:0];

  function automatic logic [31:0] ref_load(mem_ops op, logic [31:0] a);
    logic [31:0] v = '0;
    for (int i = 0; i < sz(op); i++) v[8*i +: 8] = rmem[10'(a + 32'(i))];
    if (op == MEM_LB && v[7]) v[31:8] = '1;
    if (op == MEM_LH && v[15]) v[31:16] = '1;
    return v;
  endfunction

  function automatic void ref_store(mem_ops op, logic [31:0] a, logic [31:0] wd);
    for (int i = 0; i < sz(op); i++) rmem[10'(a + 32'(i))] = wd[8*i +: 8];
  endfunction

  task automatic chk(string t, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", t, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // dcache model: answers after a configurable number of request cycles and logs the request.
  initial begin
    for (int i = 0; i < 256; i++) dmem[i] = init_word(i);
    bus.mem_d_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.mem_d_resp = 1'b0;
        cyc = 0;
      end else if (bus.mem_d_resp) begin
        bus.mem_d_resp = 1'b0;
        if (bus.mem_d_read || bus.mem_d_write) rereq++;
      end else if (bus.mem_d_read || bus.mem_d_write) begin
        if (cyc == 0) cur_lat = lat_rand ? int'($urandom_range(0, 2)) : lat_cfg;
        cyc++;
        if (cyc > cur_lat) begin
          bus.mem_d_resp = 1'b1;
          log_addr = bus.mem_d_address;
          log_wdata = bus.mem_d_wdata;
          log_be = bus.mem_d_byte_enable;
          log_rd = bus.mem_d_read;
          log_wr = bus.mem_d_write;
          log_cyc = cyc;
          cyc = 0;
          n_resp++;
          if (bus.mem_d_write)
            for (int k = 0; k < 4; k++)
              if (bus.mem_d_byte_enable[k]) dmem[bus.mem_d_address[9:2]][8*k +: 8] = bus.mem_d_wdata[8*k +: 8];
        end
      end
    end
  end

  task automatic push(mem_ops op, logic [31:0] a, logic [31:0] wd, logic [4:0] tg);
    req_t e;
    e.op = op; e.a = a; e.wd = wd; e.tg = tg;
    chk("in_ready", bus.in_ready, expq.size() != 4);
    bus.in_valid = 1'b1; bus.in_memop = op; bus.in_addr = a; bus.in_wdata = wd; bus.in_tag = tg;
    if (expq.size() != 4) expq.push_back(e);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic push_rand();
    mem_ops op;
    op = mem_ops'($urandom_range(0, 7));
    push(op, 32'($urandom_range(0, 1023)) & ~32'(sz(op) - 1), $urandom, 5'($urandom));
  endtask

  task automatic drain_one();
    req_t e;
    logic [31:0] ed;
    bit st, mis;
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin step(); n++; end
    chk("out_valid", bus.out_valid, 1);
    e = expq.pop_front();
    st = e.op inside {MEM_SB, MEM_SH, MEM_SW};
    mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = (e.op inside {MEM_LH, MEM_LHU, MEM_SH} && e.a[0]) || (e.op inside {MEM_LW, MEM_SW} && e.a[1:0] != 2'b00);
    chk("out_misalign", bus.out_misalign, mis);
`endif
    ed = (st || mis) ? 32'h0 : ref_load(e.op, e.a);
    if (st && !mis) ref_store(e.op, e.a, e.wd);
    chk("out_tag", bus.out_tag, e.tg);
    chk("out_data", bus.out_data, ed);
    chk("out_is_store", bus.out_is_store, st);
    repeat ($urandom_range(0, 2)) step();
    chk("hold_valid", bus.out_valid, 1);
    chk("hold_data", bus.out_data, ed);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("post_pop_valid", bus.out_valid, 0);
  endtask

  initial begin
    int n, act, r0;
    bus.in_valid = 1'b0; bus.in_memop = MEM_LB; bus.in_addr = '0; bus.in_wdata = '0;
    bus.in_tag = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    for (int i = 0; i < 1024; i++) rmem[i] = 8'(init_word(i / 4) >> (8 * (i % 4)));
    #1 rst = 1'b1;
    repeat (3) step();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_read", bus.mem_d_read, 0);
    chk("rst_write", bus.mem_d_write, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst_fmt_addr", bus.fmt_addr, 0);
    chk("rst_mem_addr", bus.mem_d_address, 0);
    rst = 1'b0;
    step();
    // lw 0x100: request two cycles after enqueue, held for two cycles
    lat_cfg = 1;
    push(MEM_LW, 32'h100, 32'h0, 5'd9);
    chk("lw_n1_idle", bus.mem_d_read, 0);
    step();
    chk("lw_n2_read", bus.mem_d_read, 1);
    chk("lw_be", bus.mem_d_byte_enable, 4'hf);
    chk("lw_addr", bus.mem_d_address, 32'h100);
    drain_one();
    chk("lw_req_cycles", log_cyc, 2);
    chk("lw_was_read", log_rd, 1);
    // sb 0x203
    push(MEM_SB, 32'h203, 32'h000000AB, 5'd3);
    drain_one();
    chk("sb_addr", log_addr, 32'h200);
    chk("sb_be", log_be, 4'b1000);
    chk("sb_wdata", log_wdata, 32'hAB000000);
    chk("sb_write", log_wr, 1);
    push(MEM_LBU, 32'h203, 32'h0, 5'd4);
    drain_one();
    // fill with CDB stalled; the fifth request must be ignored
    lat_rand = 1'b1;
    for (int i = 0; i < 5; i++) push_rand();
    chk("full_ready", bus.in_ready, 0);
    repeat (4) drain_one();
    act = 0;
    repeat (8) begin step(); act += int'(bus.out_valid); end
    chk("fifth_dropped", act, 0);
    // randomized traffic
    for (int i = 0; i < 40; i++)
      if ($urandom_range(0, 1) == 1 && expq.size() < 4) push_rand();
      else if (expq.size() > 0) drain_one();
    while (expq.size() > 0) drain_one();
    // flush while the head is in ACCESS with two queued behind it
    lat_rand = 1'b0; lat_cfg = 6;
    push(MEM_LW, 32'h40, 32'h0, 5'd1);
    push_rand();
    push_rand();
    chk("pre_flush_read", bus.mem_d_read, 1);
    r0 = n_resp;
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    expq.delete();
    chk("kill_in_ready", bus.in_ready, 0);
    chk("kill_read_held", bus.mem_d_read, 1);
    n = 0;
    while (bus.mem_d_resp !== 1'b1 && n < 20) begin
      chk("kill_no_valid", bus.out_valid, 0);
      step(); n++;
    end
    chk("kill_resp_seen", bus.mem_d_resp, 1);
    step();
    chk("kill_done_valid", bus.out_valid, 0);
    chk("kill_done_read", bus.mem_d_read, 0);
    chk("kill_done_ready", bus.in_ready, 1);
    act = 0;
    repeat (6) begin step(); act += int'(bus.out_valid | bus.mem_d_read | bus.mem_d_write); end
    chk("kill_quiet", act, 0);
    chk("kill_one_txn", n_resp - r0, 1);
    // flush and in_valid together in IDLE
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_memop = MEM_LW; bus.in_addr = 32'h80; bus.in_tag = 5'd2;
    step();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    act = 0;
    repeat (6) begin step(); act += int'(bus.out_valid | bus.mem_d_read | bus.mem_d_write); end
    chk("flush_enq_quiet", act, 0);
    chk("flush_enq_ready", bus.in_ready, 1);
    // reset mid-access
    lat_cfg = 8;
    push(MEM_LW, 32'h44, 32'h0, 5'd6);
    n = 0;
    while (bus.mem_d_read !== 1'b1 && n < 10) begin step(); n++; end
    chk("mid_read", bus.mem_d_read, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_read", bus.mem_d_read, 0);
    chk("async_ready", bus.in_ready, 1);
    chk("async_valid", bus.out_valid, 0);
    step();
    rst = 1'b0;
    expq.delete();
    step();
    lat_cfg = 0;
    push(MEM_LH, 32'h102, 32'h0, 5'd11);
    drain_one();
`ifdef MISALIGN_TRAP_EN
    r0 = n_resp;
    push(MEM_LW, 32'h102, 32'h0, 5'd7);
    drain_one();
    chk("mis_no_dcache", n_resp - r0, 0);
    push(MEM_SH, 32'h105, 32'h1234, 5'd8);
    drain_one();
    chk("mis_st_no_dcache", n_resp - r0, 0);
`endif
    chk("no_rerequest", rereq, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
